// File: rtl/redmule_pkg.sv
// Shared types for the RedMulE reduction writeback path: FSM states, default beat size
// and the element format enum (numbering mirrors fpnew_pkg::fp_format_e).
package redmule_pkg;

  localparam int unsigned ARRAY_WIDTH       = 16;
  localparam int unsigned RED_WB_BEAT_ELEMS = 4;

  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  typedef enum logic [1:0] {
    RWB_IDLE  = 2'd0,
    RWB_WAIT  = 2'd1,
    RWB_DRAIN = 2'd2,
    RWB_DONE  = 2'd3
  } red_wb_state_e;

  function automatic int unsigned fp_width(input fp_format_e fmt);
    case (fmt)
      FP32:    return 32;
      FP64:    return 64;
      FP8:     return 8;
      default: return 16;
    endcase
  endfunction

endpackage

// File: rtl/redmule_red_writeback.sv
// Buffers one reduction vector at a time and streams it out as BeatElems-wide beats.
// Optional stall counter output under REDMULE_RED_WB_PERF_EN.
module redmule_red_writeback
  import redmule_pkg::*;
#(
  parameter int unsigned Width     = ARRAY_WIDTH,
  parameter fp_format_e  FpFormat  = FP16,
  parameter int unsigned BeatElems = RED_WB_BEAT_ELEMS,
  localparam int unsigned BITW     = fp_width(FpFormat)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clear_i,
  input  logic                      start_i,
  input  logic [15:0]               num_rows_i,
  input  logic [Width*BITW-1:0]     red_i,
  input  logic                      red_valid_i,
  output logic                      red_ready_o,
  output logic [BeatElems*BITW-1:0] beat_o,
  output logic                      beat_valid_o,
  input  logic                      beat_ready_i,
  output logic                      beat_last_o,
  output logic                      busy_o,
  output logic                      done_o
`ifdef REDMULE_RED_WB_PERF_EN
  ,
  output logic [31:0]               stall_cnt_o
`endif
);

  localparam int unsigned NumBeats = Width / BeatElems;
  localparam int unsigned KW       = (NumBeats > 1) ? $clog2(NumBeats) : 1;
  localparam int unsigned BeatW    = BeatElems * BITW;

  if ((Width % BeatElems) != 0) begin : g_bad_beat
    $error("redmule_red_writeback: Width must be a multiple of BeatElems");
  end

  red_wb_state_e           state_q, state_d;
  logic [KW-1:0]           k_q, k_d;
  logic [15:0]             row_q, row_d;
  logic [15:0]             rows_q, rows_d;
  logic [Width*BITW-1:0]   buf_q, buf_d;

  logic last_beat, last_row, beat_hs, start_acc;

  assign last_beat = (k_q == KW'(NumBeats - 1));
  assign last_row  = (row_q == rows_q - 16'd1);
  assign beat_hs   = beat_valid_o & beat_ready_i;
  assign start_acc = (state_q == RWB_IDLE) & start_i;

  assign red_ready_o  = (state_q == RWB_WAIT);
  assign beat_valid_o = (state_q == RWB_DRAIN);
  assign beat_o       = beat_valid_o ? buf_q[int'(k_q)*BeatW +: BeatW] : '0;
  assign beat_last_o  = beat_valid_o & last_beat & last_row;
  assign busy_o       = (state_q != RWB_IDLE);
  assign done_o       = (state_q == RWB_DONE);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    row_d   = row_q;
    rows_d  = rows_q;
    buf_d   = buf_q;
    if (clear_i) begin
      state_d = RWB_IDLE;
      k_d     = '0;
      row_d   = '0;
    end else begin
      case (state_q)
        RWB_IDLE: begin
          if (start_i) begin
            rows_d  = num_rows_i;
            row_d   = '0;
            k_d     = '0;
            state_d = (num_rows_i != 16'd0) ? RWB_WAIT : RWB_DONE;
          end
        end
        RWB_WAIT: begin
          if (red_valid_i) begin
            buf_d   = red_i;
            k_d     = '0;
            state_d = RWB_DRAIN;
          end
        end
        RWB_DRAIN: begin
          if (beat_hs) begin
            if (last_beat) begin
              // Row finished: either the job is complete or fetch the next vector.
              k_d     = '0;
              row_d   = row_q + 16'd1;
              state_d = last_row ? RWB_DONE : RWB_WAIT;
            end else begin
              k_d = k_q + KW'(1);
            end
          end
        end
        RWB_DONE: state_d = RWB_IDLE;
        default:  state_d = RWB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RWB_IDLE;
      k_q     <= '0;
      row_q   <= '0;
      rows_q  <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      row_q   <= row_d;
      rows_q  <= rows_d;
      buf_q   <= buf_d;
    end
  end

`ifdef REDMULE_RED_WB_PERF_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else if (clear_i || start_acc) begin
      stall_cnt_q <= '0;
    end else if (beat_valid_o && !beat_ready_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_redmule_red_writeback.sv
// Directed bench for redmule_red_writeback: expected beats are queued as vectors are
// offered and checked against every valid beat by a negedge monitor.
module tb_redmule_red_writeback;
  import redmule_pkg::*;

  localparam int W    = 16;
  localparam int BE   = 4;
  localparam int NB   = W / BE;
  localparam int BITW = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clear, start, red_valid, beat_ready;
  logic [15:0]       num_rows;
  logic [W*BITW-1:0] red;
  logic              red_ready, beat_valid, beat_last, busy, done;
  logic [BE*BITW-1:0] beat;
`ifdef REDMULE_RED_WB_PERF_EN
  logic [31:0]       stall_cnt;
`endif

  redmule_red_writeback #(.Width(W), .FpFormat(FP16), .BeatElems(BE)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .clear_i      (clear),
    .start_i      (start),
    .num_rows_i   (num_rows),
    .red_i        (red),
    .red_valid_i  (red_valid),
    .red_ready_o  (red_ready),
    .beat_o       (beat),
    .beat_valid_o (beat_valid),
    .beat_ready_i (beat_ready),
    .beat_last_o  (beat_last),
    .busy_o       (busy),
    .done_o       (done)
`ifdef REDMULE_RED_WB_PERF_EN
    ,
    .stall_cnt_o  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [BE*BITW-1:0] beat;
    logic               last;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  logic zero_job = 1'b0;
  logic pend_done = 1'b0;
  logic prev_stall = 1'b0;
  logic prev_clear = 1'b0;
  logic [BE*BITW-1:0] prev_beat = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W*BITW-1:0] mkvec(input logic [15:0] base);
    logic [W*BITW-1:0] v;
    for (int i = 0; i < W; i++) v[i*BITW +: BITW] = 16'h3C00 + base + 16'(i);
    return v;
  endfunction

  // Monitor: beat data/last against the scoreboard, done timing, hold-while-stalled.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend_done  = 1'b0;
      prev_stall = 1'b0;
      prev_clear = 1'b0;
    end else begin
      chk("done", done, pend_done);
      pend_done = start && zero_job;
      if (prev_stall && !prev_clear) begin
        chk("stall_valid_hold", beat_valid, 1'b1);
        chk("stall_beat_hold", beat, prev_beat);
      end
      if (beat_valid) begin
        chk("no_ready_in_drain", red_ready, 1'b0);
        if (q.size() == 0) begin
          chk("unexpected_beat", beat_valid, 1'b0);
        end else begin
          chk("beat_data", beat, q[0].beat);
          chk("beat_last", beat_last, q[0].last);
          if (beat_ready) begin
            if (q[0].last) pend_done = 1'b1;
            void'(q.pop_front());
          end
        end
      end
      prev_stall = beat_valid && !beat_ready;
      prev_beat  = beat;
      prev_clear = clear;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] rows);
    num_rows = rows;
    start    = 1'b1;
    zero_job = (rows == 16'd0);
    tick();
    start    = 1'b0;
    zero_job = 1'b0;
  endtask

  task automatic send_vec(input logic [W*BITW-1:0] v, input logic last_row);
    logic got;
    got       = 1'b0;
    red       = v;
    red_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (red_ready) begin
        got = 1'b1;
        break;
      end
    end
    chk("ready_timeout", got, 1'b1);
    if (got) begin
      for (int k = 0; k < NB; k++) begin
        exp_t e;
        e.beat = v[k*BE*BITW +: BE*BITW];
        e.last = last_row && (k == NB - 1);
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    red_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 200; n++) begin
      if (!busy) break;
      tick();
    end
    chk("idle_timeout", busy, 1'b0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_ready"}, red_ready, 1'b0);
    chk({tag, "_valid"}, beat_valid, 1'b0);
    chk({tag, "_beat"}, beat, '0);
    chk({tag, "_last"}, beat_last, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; start = 1'b0; red_valid = 1'b0;
    beat_ready = 1'b0; num_rows = '0; red = '0;
    #12;
    chk_quiet("reset");
`ifdef REDMULE_RED_WB_PERF_EN
    chk("reset_stall_cnt", stall_cnt, 32'd0);
`endif
    rst_n = 1'b1;
    tick();

    // Two-row job, upstream keeps the next vector valid through DRAIN; start ignored there.
    beat_ready = 1'b1;
    do_start(16'd2);
    chk("wait_busy", busy, 1'b1);
    chk("wait_ready", red_ready, 1'b1);
    send_vec(mkvec(16'd0), 1'b0);
    red = mkvec(16'd16); red_valid = 1'b1;
    num_rows = 16'd0; start = 1'b1;
    tick();
    start = 1'b0; num_rows = 16'd2;
    send_vec(mkvec(16'd16), 1'b1);
    wait_idle();
    chk("jobA_drained", 64'(q.size()), 64'd0);

    // Zero-row job goes straight to DONE.
    do_start(16'd0);
    chk("zero_busy", busy, 1'b1);
    chk("zero_ready", red_ready, 1'b0);
    chk("zero_valid", beat_valid, 1'b0);
    tick();
    chk("zero_idle", busy, 1'b0);

    // Downstream stall for three cycles on the first beat.
    beat_ready = 1'b0;
    do_start(16'd1);
    send_vec(mkvec(16'd32), 1'b1);
    repeat (3) tick();
    beat_ready = 1'b1;
`ifdef REDMULE_RED_WB_PERF_EN
    chk("stall_cnt", stall_cnt, 32'd3);
`endif
    wait_idle();
    chk("stall_drained", 64'(q.size()), 64'd0);

    // Soft clear while beat 2 is presented, then a clean job.
    do_start(16'd1);
    send_vec(mkvec(16'd48), 1'b1);
    tick();
    tick();
    beat_ready = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    q.delete();
    chk_quiet("clear");
`ifdef REDMULE_RED_WB_PERF_EN
    chk("clear_stall_cnt", stall_cnt, 32'd0);
`endif
    beat_ready = 1'b1;
    do_start(16'd1);
    send_vec(mkvec(16'd64), 1'b1);
    wait_idle();
    chk("postclear_drained", 64'(q.size()), 64'd0);

    // Asynchronous reset in the middle of a row.
    do_start(16'd2);
    send_vec(mkvec(16'd80), 1'b0);
    tick();
    #1 rst_n = 1'b0;
    #1 chk_quiet("async_rst");
    q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    do_start(16'd1);
    send_vec(mkvec(16'd96), 1'b1);
    wait_idle();
    chk("postrst_drained", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
